// File: rtl/m72_pkg.sv
// Shared types, widths and preset memory maps for the M72/M84 window decoder.
package m72_pkg;

    localparam int unsigned M72_ADDR_W     = 20;
    localparam int unsigned M72_SDR_W      = 25;
    localparam int unsigned M72_WAIT_W     = 4;
    localparam int unsigned M72_NUM_MAPS   = 5;
    localparam int unsigned M72_PRESET_WIN = 4;

    // One decode window: compare (A & mask) against (base & mask).
    typedef struct packed {
        logic                  en;
        logic [M72_ADDR_W-1:0] base;
        logic [M72_ADDR_W-1:0] mask;
        logic [M72_SDR_W-1:0]  sdr_base;
        logic                  writable;
        logic [M72_WAIT_W-1:0] wait_cnt;
    } win_cfg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } dec_state_t;

    // Preset window for memory map map_sel (0..4), slot 0..3; the board loader
    // writes these through the cfg_* port at boot.
    function automatic win_cfg_t preset_entry(input logic [2:0] map_sel,
                                              input logic [1:0] slot);
        win_cfg_t e;
        e = '0;
        case (slot)
            2'd0: e = '{en: 1'b1, base: 20'h00000, mask: 20'hC0000,
                        sdr_base: 25'h0000000, writable: 1'b0, wait_cnt: 4'd1};
            2'd1: begin
                e = '{en: 1'b1, base: 20'h40000, mask: 20'hF0000,
                      sdr_base: 25'h0100000, writable: 1'b1, wait_cnt: 4'd0};
                case (map_sel)
                    3'd1:    e.base = 20'h60000;
                    3'd2:    e.base = 20'h50000;
                    3'd3:    e.base = 20'h70000;
                    default: e.base = 20'h40000;
                endcase
            end
            2'd2: e = '{en: 1'b1, base: 20'hD0000, mask: 20'hF0000,
                        sdr_base: 25'h0180000, writable: 1'b1, wait_cnt: 4'd1};
            default: e = '{en: (map_sel != 3'd4), base: 20'hC8000, mask: 20'hFC000,
                           sdr_base: 25'h0190000, writable: 1'b1, wait_cnt: 4'd0};
        endcase
        if (map_sel > 3'd4) begin
            e = '0;
        end
        return e;
    endfunction

endpackage

// File: rtl/win_priority_match.sv
// Combinational NUM_WIN-way window match with lowest-index priority.
module win_priority_match
    import m72_pkg::*;
#(
    parameter  int unsigned NUM_WIN = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_WIN)
)(
    input  win_cfg_t               i_tab [NUM_WIN],
    input  logic [M72_ADDR_W-1:0]  i_addr,
    input  logic                   i_mem,
    output logic [NUM_WIN-1:0]     o_hit_c,
    output logic [IDX_W-1:0]       o_idx_c,
    output logic                   o_any_c
);

    // First enabled matching entry wins; IO cycles never match.
    always_comb begin
        o_any_c = 1'b0;
        o_idx_c = '0;
        for (int unsigned i = 0; i < NUM_WIN; i++) begin
            if (!o_any_c && i_mem && i_tab[i].en &&
                ((i_addr & i_tab[i].mask) == (i_tab[i].base & i_tab[i].mask))) begin
                o_any_c = 1'b1;
                o_idx_c = IDX_W'(i);
            end
        end
        o_hit_c = o_any_c ? (NUM_WIN'(1) << o_idx_c) : '0;
    end

endmodule

// File: rtl/mem_window_decoder.sv
// Runtime-programmable CPU address-window decoder with ready pacing.
module mem_window_decoder
    import m72_pkg::*;
#(
    parameter  int unsigned NUM_WIN = 8,
    parameter  int unsigned ADDR_W  = M72_ADDR_W,
    parameter  int unsigned SDR_W   = M72_SDR_W,
    parameter  int unsigned WAIT_W  = M72_WAIT_W,
    localparam int unsigned IDX_W   = $clog2(NUM_WIN)
)(
    input  logic               CLK_32M,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_en,
    input  logic [ADDR_W-1:0]  cfg_base,
    input  logic [ADDR_W-1:0]  cfg_mask,
    input  logic [SDR_W-1:0]   cfg_sdr_base,
    input  logic               cfg_writable,
    input  logic [WAIT_W-1:0]  cfg_wait,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  A,
    input  logic               rd,
    input  logic               wr,
    input  logic               M_IO,
    output logic [NUM_WIN-1:0] win_hit,
    output logic [SDR_W-1:0]   sdr_addr,
    output logic               sdr_req,
    output logic               sdr_we,
    output logic               ready,
    output logic               prot_fault,
    input  logic               fault_clr
);

    win_cfg_t           r_tab [NUM_WIN];
    dec_state_t         r_state;
    dec_state_t         w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_rd;
    logic               r_wr;
    logic               r_mio;
    logic [WAIT_W-1:0]  r_cnt;
    logic [WAIT_W-1:0]  w_cnt_nxt;
    logic [WAIT_W-1:0]  w_wait;

    logic [NUM_WIN-1:0] w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    win_cfg_t           w_win;

    logic [NUM_WIN-1:0] w_hit_nxt;
    logic [SDR_W-1:0]   w_addr_nxt;
    logic               w_req_nxt;
    logic               w_we_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;

    win_priority_match #(.NUM_WIN(NUM_WIN)) u_match (
        .i_tab   (r_tab),
        .i_addr  (r_addr),
        .i_mem   (r_mio),
        .o_hit_c (w_hit),
        .o_idx_c (w_idx),
        .o_any_c (w_any)
    );

    assign w_win  = r_tab[w_idx];
    assign w_wait = w_any ? w_win.wait_cnt : '0;

    // Window table: cleared by reset, one entry written per cfg_wr.
    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_WIN; i++) begin
                r_tab[i] <= '0;
            end
        end else if (cfg_wr) begin
            r_tab[cfg_idx] <= '{en: cfg_en, base: cfg_base, mask: cfg_mask,
                                sdr_base: cfg_sdr_base, writable: cfg_writable,
                                wait_cnt: cfg_wait};
        end
    end

    // Capture the CPU cycle when a request is accepted in IDLE.
    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            r_addr <= '0;
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_mio  <= 1'b0;
        end else if ((r_state == IDLE) && cpu_req) begin
            r_addr <= A;
            r_rd   <= rd;
            r_wr   <= wr;
            r_mio  <= M_IO;
        end
    end

    // Next-state and next-output logic; decode results are held until IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hit_nxt   = win_hit;
        w_addr_nxt  = sdr_addr;
        w_req_nxt   = sdr_req;
        w_we_nxt    = sdr_we;
        w_ready_nxt = 1'b0;
        w_fault_nxt = prot_fault & ~fault_clr;
        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                w_hit_nxt  = w_hit;
                w_addr_nxt = w_any ? (w_win.sdr_base | SDR_W'(r_addr & ~w_win.mask)) : '0;
                w_we_nxt   = w_any & r_wr & w_win.writable;
                w_req_nxt  = w_any & (r_rd | (r_wr & w_win.writable));
                w_cnt_nxt  = w_wait;
                if (w_any && r_wr && !w_win.writable) begin
                    w_fault_nxt = 1'b1;
                end
                if (w_wait == '0) begin
                    w_state_nxt = DONE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt <= WAIT_W'(1)) begin
                    w_state_nxt = DONE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_hit_nxt   = '0;
                w_addr_nxt  = '0;
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            win_hit    <= '0;
            sdr_addr   <= '0;
            sdr_req    <= 1'b0;
            sdr_we     <= 1'b0;
            ready      <= 1'b0;
            prot_fault <= 1'b0;
        end else begin
            win_hit    <= w_hit_nxt;
            sdr_addr   <= w_addr_nxt;
            sdr_req    <= w_req_nxt;
            sdr_we     <= w_we_nxt;
            ready      <= w_ready_nxt;
            prot_fault <= w_fault_nxt;
        end
    end

endmodule

// File: tb/tb_mem_window_decoder.sv
// Self-checking bench for mem_window_decoder: timeline model plus directed vectors.
module tb_mem_window_decoder;

    logic        CLK_32M = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic        cfg_en = 1'b0;
    logic [19:0] cfg_base = '0;
    logic [19:0] cfg_mask = '0;
    logic [24:0] cfg_sdr_base = '0;
    logic        cfg_writable = 1'b0;
    logic [3:0]  cfg_wait = '0;
    logic        cpu_req = 1'b0;
    logic [19:0] A = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        M_IO = 1'b0;
    logic        fault_clr = 1'b0;
    logic [7:0]  win_hit;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_we;
    logic        ready;
    logic        prot_fault;

    mem_window_decoder dut (
        .CLK_32M(CLK_32M), .reset(reset), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
        .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
        .cfg_sdr_base(cfg_sdr_base), .cfg_writable(cfg_writable), .cfg_wait(cfg_wait),
        .cpu_req(cpu_req), .A(A), .rd(rd), .wr(wr), .M_IO(M_IO),
        .win_hit(win_hit), .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_we(sdr_we),
        .ready(ready), .prot_fault(prot_fault), .fault_clr(fault_clr)
    );

    always #15 CLK_32M = ~CLK_32M;

    int n_tot = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en [8];
    logic [19:0] m_base [8];
    logic [19:0] m_mask [8];
    logic [24:0] m_sdr [8];
    logic        m_wrt [8];
    int          m_wait [8];

    bit          m_busy = 1'b0;
    int          m_k = 0;
    logic [19:0] m_a = '0;
    logic        m_rd = 1'b0, m_wr = 1'b0, m_mio = 1'b0;
    logic [7:0]  m_hitv = '0;
    logic [24:0] m_addr = '0;
    logic        m_we = 1'b0, m_req = 1'b0, m_fault = 1'b0;
    int          m_w = 0;

    // Access k edges after acceptance: k=1 the decode result appears,
    // ready shows at k=1+wait, and k=2+wait is back in IDLE.
    always @(posedge CLK_32M) begin
        bit set_now;
        int win;
        set_now = 1'b0;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_en[i] = 1'b0; m_base[i] = '0; m_mask[i] = '0;
                m_sdr[i] = '0; m_wrt[i] = 1'b0; m_wait[i] = 0;
            end
            m_busy = 1'b0; m_k = 0; m_fault = 1'b0;
            m_hitv = '0; m_addr = '0; m_we = 1'b0; m_req = 1'b0; m_w = 0;
        end else begin
            if (m_busy) begin
                m_k++;
                if (m_k == 1) begin
                    win = -1;
                    for (int i = 7; i >= 0; i--) begin
                        if (m_en[i] && m_mio && ((m_a & m_mask[i]) == (m_base[i] & m_mask[i])))
                            win = i;
                    end
                    m_hitv = '0; m_addr = '0; m_we = 1'b0; m_req = 1'b0; m_w = 0;
                    if (win >= 0) begin
                        m_hitv[win] = 1'b1;
                        m_addr = m_sdr[win] | {5'b0, m_a & ~m_mask[win]};
                        m_we   = m_wr & m_wrt[win];
                        m_req  = m_rd | (m_wr & m_wrt[win]);
                        m_w    = m_wait[win];
                        set_now = m_wr & ~m_wrt[win];
                    end
                end
                if (m_k == m_w + 2) m_busy = 1'b0;
            end else if (cpu_req) begin
                m_busy = 1'b1; m_k = 0;
                m_a = A; m_rd = rd; m_wr = wr; m_mio = M_IO;
            end
            if (set_now) m_fault = 1'b1;
            else if (fault_clr) m_fault = 1'b0;
            if (cfg_wr) begin
                m_en[cfg_idx] = cfg_en; m_base[cfg_idx] = cfg_base;
                m_mask[cfg_idx] = cfg_mask; m_sdr[cfg_idx] = cfg_sdr_base;
                m_wrt[cfg_idx] = cfg_writable; m_wait[cfg_idx] = int'(cfg_wait);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK_32M) begin
        bit v;
        v = m_busy && (m_k >= 1);
        if (chk_en) begin
            chk("cyc_win_hit",  32'(win_hit),    v ? 32'(m_hitv) : 32'h0);
            chk("cyc_sdr_addr", 32'(sdr_addr),   v ? 32'(m_addr) : 32'h0);
            chk("cyc_sdr_we",   32'(sdr_we),     32'(v & m_we));
            chk("cyc_sdr_req",  32'(sdr_req),    32'(v & m_req));
            chk("cyc_ready",    32'(ready),      32'(v && (m_k == m_w + 1)));
            chk("cyc_fault",    32'(prot_fault), 32'(m_fault));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cfg(input int idx, input logic en, input logic [19:0] b,
                       input logic [19:0] m, input logic [24:0] s,
                       input logic wrt, input int wt);
        cfg_wr = 1'b1; cfg_idx = 3'(idx); cfg_en = en; cfg_base = b; cfg_mask = m;
        cfg_sdr_base = s; cfg_writable = wrt; cfg_wait = 4'(wt);
        @(negedge CLK_32M);
        cfg_wr = 1'b0;
    endtask

    // opt 1: fault_clr during DECODE; opt 2: disable entry 1 in the cycle after DECODE.
    task automatic access(input logic [19:0] a, input logic r, input logic w,
                          input logic mio, input int opt, output int lat,
                          output int reqc, output logic [7:0] hit,
                          output logic [24:0] addr, output logic we);
        cpu_req = 1'b1; A = a; rd = r; wr = w; M_IO = mio;
        lat = 0; reqc = 0; hit = '0; addr = '0; we = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK_32M);
            if (sdr_req) reqc++;
            if (opt == 1) fault_clr = (n == 1);
            if (opt == 2) begin
                cfg_wr = (n == 2); cfg_idx = 3'd1; cfg_en = 1'b0;
            end
            if (ready) begin
                lat = n; hit = win_hit; addr = sdr_addr; we = sdr_we;
                break;
            end
        end
        cpu_req = 1'b0; rd = 1'b0; wr = 1'b0; fault_clr = 1'b0; cfg_wr = 1'b0;
        if (lat == 0) chk("access_timeout", 32'(lat), 32'd1);
        @(negedge CLK_32M);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, reqc, nrdy;
        logic [7:0] hit;
        logic [24:0] addr;
        logic we;

        repeat (2) @(posedge CLK_32M);
        @(negedge CLK_32M);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_win_hit", 32'(win_hit), 32'h0);
        chk("rst_sdr_req", 32'(sdr_req), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_fault", 32'(prot_fault), 32'h0);

        // empty table: read misses but still completes
        access(20'h12345, 1'b1, 1'b0, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("miss_lat", 32'(lat), 32'd2);
        chk("miss_req", 32'(reqc), 32'd0);
        chk("miss_hit", 32'(hit), 32'h0);

        // writable window 0
        cfg(0, 1'b1, 20'h40000, 20'hE0000, 25'h100000, 1'b1, 0);
        access(20'h41234, 1'b0, 1'b1, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("w0_hit", 32'(hit), 32'h01);
        chk("w0_addr", 32'(addr), 32'h101234);
        chk("w0_we", 32'(we), 32'h1);
        chk("w0_lat", 32'(lat), 32'd2);
        chk("w0_req", 32'(reqc), 32'd1);

        // IO cycle to the same address never hits
        access(20'h41234, 1'b1, 1'b0, 1'b0, 0, lat, reqc, hit, addr, we);
        chk("io_hit", 32'(hit), 32'h0);
        chk("io_req", 32'(reqc), 32'd0);

        // overlapping windows 1 and 3: lowest index wins, 3 wait states
        cfg(1, 1'b1, 20'hC0000, 20'hF0000, 25'h200000, 1'b1, 3);
        cfg(3, 1'b1, 20'hC0000, 20'hFFF00, 25'h300000, 1'b1, 0);
        access(20'hC0010, 1'b1, 1'b0, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("prio_hit", 32'(hit), 32'h02);
        chk("prio_addr", 32'(addr), 32'h200010);
        chk("prio_lat", 32'(lat), 32'd5);
        chk("prio_req", 32'(reqc), 32'd4);

        // read-only ROM window 2
        cfg(2, 1'b1, 20'h00000, 20'hF0000, 25'h000000, 1'b0, 0);
        access(20'h00100, 1'b1, 1'b0, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("rom_rd_hit", 32'(hit), 32'h04);
        chk("rom_rd_addr", 32'(addr), 32'h100);
        chk("rom_rd_req", 32'(reqc), 32'd1);
        chk("rom_rd_fault", 32'(prot_fault), 32'h0);
        access(20'h00100, 1'b0, 1'b1, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("rom_wr_hit", 32'(hit), 32'h04);
        chk("rom_wr_we", 32'(we), 32'h0);
        chk("rom_wr_req", 32'(reqc), 32'd0);
        chk("rom_wr_lat", 32'(lat), 32'd2);
        chk("rom_wr_fault", 32'(prot_fault), 32'h1);
        repeat (3) @(negedge CLK_32M);
        chk("fault_sticky", 32'(prot_fault), 32'h1);
        fault_clr = 1'b1;
        @(negedge CLK_32M);
        fault_clr = 1'b0;
        chk("fault_cleared", 32'(prot_fault), 32'h0);
        access(20'h00100, 1'b0, 1'b1, 1'b1, 1, lat, reqc, hit, addr, we);
        chk("fault_set_beats_clr", 32'(prot_fault), 32'h1);
        fault_clr = 1'b1;
        @(negedge CLK_32M);
        fault_clr = 1'b0;
        chk("fault_cleared2", 32'(prot_fault), 32'h0);

        // disable the winner right after DECODE: in-flight access unaffected
        cfg(3, 1'b0, 20'hC0000, 20'hFFF00, 25'h300000, 1'b1, 0);
        access(20'hC0010, 1'b1, 1'b0, 1'b1, 2, lat, reqc, hit, addr, we);
        chk("inflight_hit", 32'(hit), 32'h02);
        chk("inflight_addr", 32'(addr), 32'h200010);
        chk("inflight_lat", 32'(lat), 32'd5);
        access(20'hC0010, 1'b1, 1'b0, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("after_dis_hit", 32'(hit), 32'h0);
        chk("after_dis_lat", 32'(lat), 32'd2);
        chk("after_dis_req", 32'(reqc), 32'd0);

        // reset during WAIT aborts with no ready and clears the table
        cfg(4, 1'b1, 20'h60000, 20'hF0000, 25'h400000, 1'b1, 5);
        cpu_req = 1'b1; A = 20'h60000; rd = 1'b1; wr = 1'b0; M_IO = 1'b1;
        repeat (4) @(negedge CLK_32M);
        chk("wait_req", 32'(sdr_req), 32'h1);
        chk("wait_hit", 32'(win_hit), 32'h10);
        chk("wait_ready", 32'(ready), 32'h0);
        reset = 1'b1; cpu_req = 1'b0; rd = 1'b0;
        @(negedge CLK_32M);
        reset = 1'b0;
        chk("abort_hit", 32'(win_hit), 32'h0);
        chk("abort_addr", 32'(sdr_addr), 32'h0);
        chk("abort_req", 32'(sdr_req), 32'h0);
        nrdy = 0;
        repeat (10) begin
            @(negedge CLK_32M);
            if (ready) nrdy++;
        end
        chk("abort_no_ready", 32'(nrdy), 32'd0);
        access(20'h60000, 1'b1, 1'b0, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("post_rst_hit", 32'(hit), 32'h0);
        chk("post_rst_lat", 32'(lat), 32'd2);
        access(20'h41234, 1'b0, 1'b1, 1'b1, 0, lat, reqc, hit, addr, we);
        chk("post_rst_w0_hit", 32'(hit), 32'h0);
        chk("post_rst_w0_we", 32'(we), 32'h0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
